yin_threshold_module: RTL

- Downstream stage of the cumulative-mean-normalised difference block (modiff_module) in the YIN pitch path.
- Captures the MAX_TAU normalised difference values once that block raises ready.
- Performs the YIN absolute-threshold step: first tau below threshold, then walk to its local minimum.
- Falls back to the global minimum when no value is below threshold, and presents the chosen tau with a level handshake to the pitch/period consumer.

---
 rtl/yin_pkg.sv | 18 +
 rtl/yin_threshold_module.sv | 137 +++++++++++++
 2 files changed

// File: rtl/yin_pkg.sv
// Shared constants and types for the YIN absolute-threshold stage.
package yin_pkg;

  localparam int INTERMEDIATE_DATA_WIDTH = 64;
  localparam int MAX_TAU                 = 40;
  localparam int TAU_MIN                 = 2;
  localparam int TAU_BITS                = 6;

  typedef logic [INTERMEDIATE_DATA_WIDTH-1:0] diff_word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    DESCEND = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/yin_threshold_module.sv
// YIN absolute-threshold step: captures a frame of normalised differences, finds the
// first sub-threshold lag and walks to its local minimum, else reports the global minimum.
module yin_threshold_module #(
  parameter int INTERMEDIATE_DATA_WIDTH = 64,
  parameter int MAX_TAU                 = 40,
  parameter int TAU_MIN                 = 2,
  parameter int TAU_BITS                = 6
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [MAX_TAU*INTERMEDIATE_DATA_WIDTH-1:0] results,
  input  logic                                  results_ready,
  input  logic [INTERMEDIATE_DATA_WIDTH-1:0]    threshold,
  output logic                                  busy,
  output logic                                  tau_valid,
  output logic [TAU_BITS-1:0]                   tau_out,
  output logic                                  found,
  output logic [INTERMEDIATE_DATA_WIDTH-1:0]    min_value
);
  import yin_pkg::*;

  localparam int W = INTERMEDIATE_DATA_WIDTH;
  localparam logic [TAU_BITS-1:0] FIRST_IDX = TAU_BITS'(TAU_MIN);
  localparam logic [TAU_BITS-1:0] LAST_IDX  = TAU_BITS'(MAX_TAU - 1);

  // Handshake: results_ready is a level; a frame is captured only from IDLE, and
  // tau_valid stays high in DONE until results_ready is seen low.
  state_t              state;
  state_t              state_next;

  logic [W-1:0]        frame_buf [MAX_TAU];
  logic [W-1:0]        thr;
  logic [W-1:0]        gmin_val;
  logic [TAU_BITS-1:0] gmin_idx;
  logic [TAU_BITS-1:0] idx;
  logic [TAU_BITS-1:0] nxt_idx;
  logic [W-1:0]        cur_val;
  logic [W-1:0]        nxt_val;
  logic                at_last;
  logic                below_thr;
  logic                below_gmin;
  logic                descend_more;

  assign at_last      = (idx == LAST_IDX);
  assign nxt_idx      = at_last ? idx : idx + 1'b1;
  assign cur_val      = frame_buf[idx];
  assign nxt_val      = frame_buf[nxt_idx];
  assign below_thr    = (cur_val < thr);
  assign below_gmin   = (cur_val < gmin_val);
  assign descend_more = !at_last && (nxt_val < cur_val);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (results_ready) state_next = SCAN;
      SCAN: begin
        if (below_thr)    state_next = DESCEND;
        else if (at_last) state_next = DONE;
      end
      DESCEND: if (!descend_more) state_next = DONE;
      DONE:    if (!results_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == SCAN) || (state == DESCEND);
    tau_valid = (state == DONE);
  end

  // Frame storage carries no reset; its contents only matter after a capture.
  always_ff @(posedge clk) begin
    if (state == IDLE && results_ready) begin
      for (int t = 0; t < MAX_TAU; t++) begin
        frame_buf[t] <= results[t*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      thr       <= '0;
      idx       <= '0;
      gmin_idx  <= '0;
      gmin_val  <= '0;
      tau_out   <= '0;
      found     <= 1'b0;
      min_value <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (results_ready) begin
            thr      <= threshold;
            idx      <= FIRST_IDX;
            gmin_idx <= FIRST_IDX;
            gmin_val <= results[TAU_MIN*W +: W];
          end
        end
        SCAN: begin
          if (!below_thr) begin
            if (below_gmin) begin
              gmin_idx <= idx;
              gmin_val <= cur_val;
            end
            // The last entry may itself be the new minimum, so fold it in here.
            if (at_last) begin
              tau_out   <= below_gmin ? idx : gmin_idx;
              min_value <= below_gmin ? cur_val : gmin_val;
              found     <= 1'b0;
            end else begin
              idx <= nxt_idx;
            end
          end
        end
        DESCEND: begin
          if (descend_more) begin
            idx <= nxt_idx;
          end else begin
            tau_out   <= idx;
            min_value <= cur_val;
            found     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
